shift_frame_engine: RTL
=======================

Name: shift_frame_engine

Overview:
- Parametrised successor to the team's fixed 8-bit serial-in/serial-out shifter.
- Full-duplex framed shift engine:
  - optional parallel load at frame start;
  - configurable shift direction (MSB-first or LSB-first);
  - configurable frame length;
  - pause via enable, abort, back-to-back frames;
  - parallel snapshot of received data at frame end.
- Sits between a byte/word-level controller and a serial link (SPI-like or test-chain style).

Parameters:
WIDTH, 8, shift register width in bits; legal range 2..64
FRAME_LEN, 8, shifts per frame; legal range 1..WIDTH
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start  input  1  begin frame; sampled in IDLE or DONE only
load  input  1  with start: 1 = shift_reg <= pdata, 0 = keep current contents
dir  input  1  sampled at start: 0 = shift left / MSB-first, 1 = shift right / LSB-first
enable  input  1  advance one shift this cycle (SHIFT state only)
abort  input  1  cancel the current frame
in  input  1  serial data in
pdata  input  WIDTH  parallel load data
out  output  1  serial data out (registered)
pout  output  WIDTH  received-frame snapshot
done  output  1  one-cycle pulse at frame completion
busy  output  1  high while a frame is in progress
rx_parity  output  1  XOR of the frame's serial-in bits (see Optional Feature)

Behaviour:
- Reset (async, any state): state = IDLE; shift_reg, bit_count, out, pout, done, busy, rx_parity and the latched dir all = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1: latch dir, apply load rule, bit_count <= 0, go to SHIFT.
  - enable has no effect in IDLE.
- SHIFT:
  - busy = 1 from the cycle after start was accepted.
  - With enable = 1 each clock:
    - dir = 0: out <= shift_reg[WIDTH-1]; shift_reg <= {shift_reg[WIDTH-2:0], in}.
    - dir = 1: out <= shift_reg[0]; shift_reg <= {in, shift_reg[WIDTH-1:1]}.
    - bit_count increments.
  - enable = 0: everything holds (pause); busy stays 1; out holds.
  - Last shift: enabled shift with bit_count == FRAME_LEN-1.
    - pout <= post-shift shift_reg value.
    - Go to DONE.
    - done = 1 and busy = 0 in the following cycle.
  - start during SHIFT is ignored.
- DONE (one cycle):
  - done = 1, busy = 0.
  - start = 1: accepted exactly as in IDLE, go to SHIFT (back-to-back frame, no gap cycle).
  - Otherwise go to IDLE.
- abort:
  - Highest priority after reset, valid in any state.
  - Next state = IDLE; busy <= 0; done <= 0.
  - pout and shift_reg hold; no done pulse is produced.
  - abort and start in the same cycle: abort wins.
- Latency:
  - First serial-out bit appears on out one clock after the first enabled shift edge.
  - done appears one clock after the last enabled shift.
- Partial frames: FRAME_LEN < WIDTH shifts only FRAME_LEN bits.
  - Received bits occupy the low (dir = 0) or high (dir = 1) FRAME_LEN bits of pout.
  - The remaining bits are unshifted load bits.
- bit_count never exceeds FRAME_LEN-1 and never wraps mid-frame.
- out persists between frames until the next enabled shift.

Optional Feature:
- Macro: SHIFT_FRAME_PARITY_EN.
- Defined:
  - A running XOR accumulates each sampled in bit during enabled shifts; it is cleared when start is accepted.
  - rx_parity <= final XOR (including the last bit) in the same edge that updates pout.
  - rx_parity is valid with done and held until the next frame completes.
  - abort clears the accumulator; rx_parity holds.
- Not defined: rx_parity tied 0; no accumulator logic.

Test Plan:
- Reset mid-frame: after 3 of 8 shifts, assert reset -> out=0, pout=0, done=0, busy=0 immediately (async), state IDLE.
- WIDTH=8, FRAME_LEN=8, start+load pdata=8'hA5, dir=0, enable held high, in stream 1,1,0,0,1,0,1,0 -> out sequence 1,0,1,0,0,1,0,1; done pulses one cycle after the 8th shift; pout=8'hCA; busy high for exactly 8 cycles.
- Same frame with dir=1, pdata=8'hA5 -> out sequence 1,0,1,0,0,1,0,1 (LSB first); in stream 0,1,0,1,0,0,1,1 -> pout=8'hCA.
- Pause: enable low for 5 cycles after shift 4 -> out and busy hold; done arrives 5 cycles later than in the unpaused run; data identical.
- Back-to-back and abort:
  - start asserted during the DONE cycle -> new frame starts with no IDLE gap.
  - abort at shift 5 of the second frame -> no done; pout keeps the first frame's value.
  - start+abort in the same cycle -> stays IDLE.
- FRAME_LEN=4, WIDTH=8, pdata=8'hF0, dir=0, in=1,0,1,1 -> pout=8'h0B; with SHIFT_FRAME_PARITY_EN, rx_parity=1.

Source files
------------

// File: rtl/shift_frame_engine_if.sv
// Controller <-> shift_frame_engine bus.
// Ports: start/load/dir/enable/abort/in/pdata (master->slave);
//        out/pout/done/busy/rx_parity (slave->master).
interface shift_frame_engine_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             load;
  logic             dir;
  logic             enable;
  logic             abort;
  logic             in;
  logic [WIDTH-1:0] pdata;
  logic             out;
  logic [WIDTH-1:0] pout;
  logic             done;
  logic             busy;
  logic             rx_parity;

  modport master (
    output start, load, dir, enable, abort, in, pdata,
    input  out, pout, done, busy, rx_parity
  );

  modport slave (
    input  start, load, dir, enable, abort, in, pdata,
    output out, pout, done, busy, rx_parity
  );
endinterface

// File: rtl/shift_frame_engine.sv
// Framed full-duplex shift engine: load, shift MSB/LSB-first, snapshot.
// Ports: clk, reset (async, active high), sfe (slave modport of
// shift_frame_engine_if). Optional macro SHIFT_FRAME_PARITY_EN enables
// the received-bit parity output rx_parity (tied 0 otherwise).
module shift_frame_engine #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(WIDTH) + 1
) (
  input logic                 clk,
  input logic                 reset,
  shift_frame_engine_if.slave sfe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             idle_like;
  logic             accept;
  logic             step;
  logic             last;

  // DONE accepts a new start just like IDLE (back-to-back frames).
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = ~sfe.abort & idle_like & sfe.start;
  assign step      = ~sfe.abort & (state_q == S_SHIFT) & sfe.enable;
  assign last      = step & (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dir_d   = dir_q;
    unique case (1'b1)
      sfe.abort: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      accept: begin
        state_d = S_SHIFT;
        dir_d   = sfe.dir;
        cnt_d   = '0;
        if (sfe.load) sreg_d = sfe.pdata;
      end
      step: begin
        if (dir_q) begin
          out_d  = sreg_q[0];
          sreg_d = {sfe.in, sreg_q[WIDTH-1:1]};
        end else begin
          out_d  = sreg_q[WIDTH-1];
          sreg_d = {sreg_q[WIDTH-2:0], sfe.in};
        end
        if (last) begin
          pout_d  = sreg_d;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
      end
    endcase
  end

  // Flags are registered images of the next state.
  assign busy_d = (state_d == S_SHIFT);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      pout_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sfe.out  = out_q;
  assign sfe.pout = pout_q;
  assign sfe.busy = busy_q;
  assign sfe.done = done_q;

`ifdef SHIFT_FRAME_PARITY_EN
  logic acc_q, acc_d;
  logic par_q, par_d;

  // Result is published with pout; abort only drops the running sum.
  always_comb begin
    acc_d = acc_q;
    par_d = par_q;
    if (sfe.abort || accept) begin
      acc_d = 1'b0;
    end else if (step) begin
      acc_d = acc_q ^ sfe.in;
      if (last) par_d = acc_q ^ sfe.in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      par_q <= par_d;
    end
  end

  assign sfe.rx_parity = par_q;
`else
  assign sfe.rx_parity = 1'b0;
`endif

endmodule
